sspm_tdm_scheduler: RTL and testbench
=====================================

SSPM_TDM_SCHEDULER -- requirements
Module: sspm_tdm_scheduler

Interface
REQ-001 Parameter CORES, default 3: number of OCP requesters (connector slots) sharing one SSPM bank.
REQ-002 Parameter ADDR_W, default 10: SSPM word-address width.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port io_m_cmd  in  3*CORES: per-core OCP master command (IDLE=0, WR=1, RD=2); non-IDLE is valid for one cycle.
REQ-006 Port io_m_addr  in  32*CORES: per-core byte address.
REQ-007 Port io_m_data  in  32*CORES: per-core write data.
REQ-008 Port io_m_byteen  in  4*CORES: per-core byte enables.
REQ-009 Port io_s_resp  out  2*CORES: per-core OCP response (NULL=0, DVA=1).
REQ-010 Port io_s_data  out  32*CORES: per-core read data.
REQ-011 Port io_mem_addr  out  ADDR_W: SSPM word address.
REQ-012 Port io_mem_wr_data  out  32: SSPM write data.
REQ-013 Port io_mem_byteen  out  4: SSPM byte write mask.
REQ-014 Port io_mem_wr_en  out  1: SSPM write strobe.
REQ-015 Port io_mem_rd_en  out  1: SSPM read strobe.
REQ-016 Port io_mem_rd_data  in  32: SSPM read data, valid the cycle after io_mem_rd_en.
REQ-017 Port io_slot_owner  out  clog2(CORES): current TDM owner index.
REQ-018 Port io_ovf  out  CORES: sticky per-core protocol-violation flags.

Function
REQ-019 Core i with non-IDLE io_m_cmd in cycle t SHALL capture cmd/addr/data/byteen into its pending buffer, visible from cycle t+1.
REQ-020 TDM schedule: slot = 2 cycles (phase 0 issue, phase 1 response); owner advances 0,1,...,CORES-1,0 after each phase 1; a full round = 2*CORES cycles, independent of traffic.
REQ-021 Phase 0, owner pending: io_mem_addr = addr[ADDR_W+1:2], wr_en (WR) or rd_en (RD) high exactly one cycle; wr_data/byteen from buffer.
REQ-022 Phase 0, owner idle: all io_mem strobes low; slot is wasted, never given to another core.
REQ-023 Phase 1 after an issue: owner io_s_resp = DVA for exactly one cycle; io_s_data = io_mem_rd_data for RD, 0 for WR; pending cleared at end of cycle.
REQ-024 io_s_resp = NULL and io_s_data = 0 for every core in every other cycle.
REQ-025 Latency: request at cycle t gets DVA between t+2 (best) and t+2*CORES+1 (worst: command arrives in its own phase 0).
REQ-026 Non-IDLE command while pending and not in own phase-1 cycle: dropped, pending unchanged, io_ovf[i] set and held until reset.
REQ-027 Non-IDLE command in own phase-1 (DVA) cycle: accepted; buffer reloaded with new request, not cleared.
REQ-028 io_m_cmd values 3..7: treated as IDLE, io_ovf[i] set.
REQ-029 Address bits above ADDR_W+1 and [1:0] ignored; no range error raised.

Reset
REQ-030 On reset: owner = 0, phase = 0, all pending buffers cleared, io_ovf = 0.
REQ-031 During and in the cycle after reset: io_s_resp = NULL, io_s_data = 0, io_mem_wr_en = io_mem_rd_en = 0, io_mem_addr/wr_data/byteen = 0.
REQ-032 Reset mid-transaction discards in-flight requests; no DVA issued for them afterwards.

Structure
REQ-033 Package sspm_pkg holds OCP cmd/resp encodings, default CORES and ADDR_W, and the pending-request record type.
REQ-034 One sub-module sspm_req_buffer (single-core capture/hold/clear and ovf flag), instantiated CORES times; the TDM counter and mem mux remain in the top.

Verification
REQ-035 Reset, then core 1 WR addr 0x10 data 0xDEADBEEF byteen 0xF in cycle 0 -> io_mem_wr_en at cycle 2 with io_mem_addr 0x4, DVA on core 1 at cycle 3.
REQ-036 Core 2 RD 0x10 after REQ-035, memory model returns 0xDEADBEEF -> core 2 io_s_data = 0xDEADBEEF with DVA in its phase 1; other cores NULL/0.
REQ-037 All three cores RD in the same cycle -> issues in order 0,1,2 on consecutive slots, exactly one strobe per slot, all DVAs within 2*CORES+1 cycles.
REQ-038 Core 0 RD arriving in its own phase 0 -> DVA exactly 2*CORES+1 = 7 cycles later.
REQ-039 Core 1 second WR while pending -> dropped, io_ovf = 3'b010; a WR in its DVA cycle -> accepted, DVA one round later, io_ovf unchanged.
REQ-040 Assert reset in the phase-0 cycle of a core-0 RD -> no DVA ever for it, owner = 0, strobes 0 the following cycle.

Source files
------------

// File: rtl/sspm_pkg.sv
`default_nettype none
// sspm_pkg: OCP command/response encodings, default sizing and the pending-request
// record shared by the SSPM TDM scheduler and its per-core request buffers.
package sspm_pkg;

  localparam int DEFAULT_CORES  = 3;
  localparam int DEFAULT_ADDR_W = 10;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;

  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_RESP  = 1'b1
  } phase_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/sspm_req_buffer.sv
`default_nettype none
// sspm_req_buffer: holds one core's outstanding OCP request until its TDM response
// cycle, and raises a sticky flag on dropped or malformed commands.
module sspm_req_buffer
  import sspm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [3:0]  byteen,
  input  logic        clear,
  output req_t        req,
  output logic        ovf
);

  logic valid_cmd;
  logic bad_cmd;
  logic accept;

  // The response cycle frees the slot, so a new request may reload it in that same cycle.
  always_comb begin
    valid_cmd = (cmd == CMD_WR) || (cmd == CMD_RD);
    bad_cmd   = (cmd != CMD_IDLE) && !valid_cmd;
    accept    = !req.valid || clear;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req <= '0;
      ovf <= 1'b0;
    end else begin
      if (valid_cmd && accept) begin
        req <= '{valid: 1'b1, cmd: cmd, addr: addr, data: data, byteen: byteen};
      end else if (clear) begin
        req <= '0;
      end
      if (bad_cmd || (valid_cmd && !accept)) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sspm_tdm_scheduler.sv
`default_nettype none
// sspm_tdm_scheduler: fixed round-robin TDM arbitration of CORES OCP requesters onto
// one SSPM bank; each core owns a 2-cycle slot (issue, response) every round.
module sspm_tdm_scheduler
  import sspm_pkg::*;
#(
  parameter  int CORES  = DEFAULT_CORES,
  parameter  int ADDR_W = DEFAULT_ADDR_W,
  localparam int OWN_W  = (CORES > 1) ? $clog2(CORES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3*CORES-1:0]    io_m_cmd,
  input  logic [32*CORES-1:0]   io_m_addr,
  input  logic [32*CORES-1:0]   io_m_data,
  input  logic [4*CORES-1:0]    io_m_byteen,
  output logic [2*CORES-1:0]    io_s_resp,
  output logic [32*CORES-1:0]   io_s_data,
  output logic [ADDR_W-1:0]     io_mem_addr,
  output logic [31:0]           io_mem_wr_data,
  output logic [3:0]            io_mem_byteen,
  output logic                  io_mem_wr_en,
  output logic                  io_mem_rd_en,
  input  logic [31:0]           io_mem_rd_data,
  output logic [OWN_W-1:0]      io_slot_owner,
  output logic [CORES-1:0]      io_ovf
);

  phase_t           phase_q, phase_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic             issued_q, issued_d;
  req_t             pend [CORES];
  req_t             own_req;
  logic [CORES-1:0] clear;
  logic             issue;
  logic             respond;
  logic             unused_addr_bits;

  for (genvar i = 0; i < CORES; i++) begin : g_core
    sspm_req_buffer u_buf (
      .clk    (clk),
      .reset  (reset),
      .cmd    (io_m_cmd[3*i +: 3]),
      .addr   (io_m_addr[32*i +: 32]),
      .data   (io_m_data[32*i +: 32]),
      .byteen (io_m_byteen[4*i +: 4]),
      .clear  (clear[i]),
      .req    (pend[i]),
      .ovf    (io_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_ISSUE;
      owner_q  <= '0;
      issued_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      owner_q  <= owner_d;
      issued_q <= issued_d;
    end
  end

  // The slot advances regardless of traffic; issued_q remembers whether phase 0 used it.
  always_comb begin
    phase_d  = phase_q;
    owner_d  = owner_q;
    issued_d = 1'b0;
    if (phase_q == PH_ISSUE) begin
      phase_d  = PH_RESP;
      issued_d = own_req.valid;
    end else begin
      phase_d = PH_ISSUE;
      owner_d = (owner_q == OWN_W'(CORES - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  always_comb begin
    own_req = '0;
    for (int i = 0; i < CORES; i++) begin
      if (owner_q == i[OWN_W-1:0]) own_req = pend[i];
    end
  end

  always_comb begin
    issue          = !reset && (phase_q == PH_ISSUE) && own_req.valid;
    respond        = !reset && (phase_q == PH_RESP) && issued_q;
    io_mem_addr    = '0;
    io_mem_wr_data = '0;
    io_mem_byteen  = '0;
    io_mem_wr_en   = 1'b0;
    io_mem_rd_en   = 1'b0;
    if (issue) begin
      io_mem_addr    = own_req.addr[ADDR_W+1:2];
      io_mem_wr_data = own_req.data;
      io_mem_byteen  = own_req.byteen;
      io_mem_wr_en   = (own_req.cmd == CMD_WR);
      io_mem_rd_en   = (own_req.cmd == CMD_RD);
    end
    io_s_resp = '0;
    io_s_data = '0;
    clear     = '0;
    for (int i = 0; i < CORES; i++) begin
      if (respond && (owner_q == i[OWN_W-1:0])) begin
        clear[i]             = 1'b1;
        io_s_resp[2*i +: 2]  = RESP_DVA;
        if (pend[i].cmd == CMD_RD) io_s_data[32*i +: 32] = io_mem_rd_data;
      end
    end
  end

  assign io_slot_owner    = owner_q;
  assign unused_addr_bits = ^{own_req.addr[31:ADDR_W+2], own_req.addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_sspm_tdm_scheduler.sv
`default_nettype none
// Bench for sspm_tdm_scheduler: directed vector table, then random traffic checked
// against a reference model derived from cycle-count slot arithmetic.
module tb_sspm_tdm_scheduler;
  import sspm_pkg::*;

  localparam int C  = 3;
  localparam int AW = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3*C-1:0]    m_cmd = '0;
  logic [32*C-1:0]   m_addr = '0;
  logic [32*C-1:0]   m_data = '0;
  logic [4*C-1:0]    m_be = '0;
  logic [2*C-1:0]    s_resp;
  logic [32*C-1:0]   s_data;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wd;
  logic [3:0]        mem_be;
  logic              mem_wr;
  logic              mem_rd;
  logic [31:0]       mem_rdata = '0;
  logic [1:0]        owner;
  logic [C-1:0]      ovf;

  always #5 clk = ~clk;

  sspm_tdm_scheduler #(.CORES(C), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .io_m_cmd(m_cmd), .io_m_addr(m_addr), .io_m_data(m_data), .io_m_byteen(m_be),
    .io_s_resp(s_resp), .io_s_data(s_data),
    .io_mem_addr(mem_addr), .io_mem_wr_data(mem_wd), .io_mem_byteen(mem_be),
    .io_mem_wr_en(mem_wr), .io_mem_rd_en(mem_rd), .io_mem_rd_data(mem_rdata),
    .io_slot_owner(owner), .io_ovf(ovf)
  );

  // SSPM bank driven by the DUT's strobes; read data lands the cycle after rd_en.
  bit [31:0] bank [1<<AW];
  always @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) if (mem_be[b]) bank[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
    end
    if (mem_rd) mem_rdata <= bank[mem_addr];
  end

  // Reference model state
  int          cyc = 0;
  bit          q_v   [C];
  logic [2:0]  q_cmd [C];
  logic [31:0] q_a   [C];
  logic [31:0] q_d   [C];
  logic [3:0]  q_b   [C];
  bit          q_issued = 1'b0;
  bit [C-1:0]  q_ovf = '0;
  bit          post_rst = 1'b0;
  bit [31:0]   ref_mem [1<<AW];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    int ph, own;
    logic [2*C-1:0]  e_resp;
    logic [32*C-1:0] e_data;
    logic            e_wr, e_rd;
    logic [AW-1:0]   e_addr;
    logic [31:0]     e_wd;
    logic [3:0]      e_be;
    ph = cyc % 2; own = (cyc / 2) % C;
    e_resp = '0; e_data = '0; e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
    if (!reset && ph == 0 && q_v[own]) begin
      e_wr = (q_cmd[own] == CMD_WR);
      e_rd = (q_cmd[own] == CMD_RD);
      e_addr = q_a[own][AW+1:2];
      e_wd = q_d[own];
      e_be = q_b[own];
    end
    if (!reset && ph == 1 && q_issued) begin
      e_resp[2*own +: 2] = RESP_DVA;
      if (q_cmd[own] == CMD_RD) e_data[32*own +: 32] = ref_mem[q_a[own][AW+1:2]];
    end
    check("model_strobes", {mem_wr, mem_rd}, {e_wr, e_rd});
    if (e_wr || e_rd || reset || post_rst)
      check("model_mem_bus", {mem_addr, mem_wd, mem_be}, {e_addr, e_wd, e_be});
    check("model_resp", s_resp, e_resp);
    check("model_s_data", s_data, e_data);
    if (!reset) begin
      check("model_owner", owner, own[1:0]);
      check("model_ovf", ovf, q_ovf);
    end
  endtask

  task automatic model_commit();
    int ph, own;
    bit issue_now, dva;
    logic [2:0] c;
    logic [AW-1:0] w;
    if (reset) begin
      for (int i = 0; i < C; i++) q_v[i] = 1'b0;
      q_issued = 1'b0; q_ovf = '0; cyc = 0; post_rst = 1'b1;
      return;
    end
    post_rst = 1'b0;
    ph = cyc % 2; own = (cyc / 2) % C;
    issue_now = (ph == 0) && q_v[own];
    if (issue_now && q_cmd[own] == CMD_WR) begin
      w = q_a[own][AW+1:2];
      for (int b = 0; b < 4; b++) if (q_b[own][b]) ref_mem[w][8*b +: 8] = q_d[own][8*b +: 8];
    end
    for (int i = 0; i < C; i++) begin
      c = m_cmd[3*i +: 3];
      dva = (ph == 1) && q_issued && (own == i);
      if (c == CMD_WR || c == CMD_RD) begin
        if (!q_v[i] || dva) begin
          q_v[i] = 1'b1; q_cmd[i] = c; q_a[i] = m_addr[32*i +: 32];
          q_d[i] = m_data[32*i +: 32]; q_b[i] = m_be[4*i +: 4];
        end else q_ovf[i] = 1'b1;
      end else begin
        if (c != CMD_IDLE) q_ovf[i] = 1'b1;
        if (dva) q_v[i] = 1'b0;
      end
    end
    q_issued = issue_now;
    cyc++;
  endtask

  task automatic drive(input bit rst, input logic [3*C-1:0] cmd, input logic [32*C-1:0] a,
                       input logic [32*C-1:0] d, input logic [4*C-1:0] be);
    reset = rst; m_cmd = cmd; m_addr = a; m_data = d; m_be = be;
    @(negedge clk);
    model_check();
  endtask

  task automatic finish_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rst;
    logic [8:0]  cmd;
    logic [31:0] addr, data;
    logic [3:0]  be;
    bit          ewr, erd;
    logic [AW-1:0] eaddr;
    logic [31:0] ewd;
    logic [3:0]  ebe;
    logic [5:0]  eresp;
    logic [95:0] edata;
    logic [2:0]  eovf;
    logic [1:0]  eown;
  } vec_t;
  vec_t tbl[$];

  function automatic void v(bit rst, logic [8:0] cmd, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                            bit ewr, bit erd, logic [AW-1:0] ea, logic [31:0] ewd, logic [3:0] ebe,
                            logic [5:0] er, logic [95:0] ed, logic [2:0] eo, logic [1:0] eown);
    vec_t t;
    t.rst = rst; t.cmd = cmd; t.addr = a; t.data = d; t.be = be;
    t.ewr = ewr; t.erd = erd; t.eaddr = ea; t.ewd = ewd; t.ebe = ebe;
    t.eresp = er; t.edata = ed; t.eovf = eo; t.eown = eown;
    tbl.push_back(t);
  endfunction

  function automatic void idle(bit rst, logic [2:0] eo, logic [1:0] eown);
    v(rst, 9'o000, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, '0, 32'h0, 4'h0, 6'h00, 96'h0, eo, eown);
  endfunction

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    logic [3*C-1:0]  rc;
    logic [32*C-1:0] ra, rdat;
    logic [4*C-1:0]  rb;
    bit              rr;
    int              r;
    logic [31:0]     a1;

    idle(1, 0, 0); idle(1, 0, 0);
    v(0, 9'o010, 32'h10, DB, 4'hF, 0, 0, 10'h0, 32'h0, 4'h0, 6'h00, 96'h0, 3'b000, 0);   // c0
    idle(0, 0, 0);                                                                  // c1
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 1, 0, 10'h4, DB, 4'hF, 6'h00, 96'h0, 3'b000, 1);    // c2
    v(0, 9'o200, 32'h10, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0, 6'h04, 96'h0, 3'b000, 1); // c3
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 0, 1, 10'h4, 32'h0, 4'h0, 6'h00, 96'h0, 3'b000, 2);  // c4
    v(0, 9'o222, 32'h10, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0, 6'h10, {DB, 64'h0}, 3'b000, 2);
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 0, 1, 10'h4, 32'h0, 4'h0, 6'h00, 96'h0, 3'b000, 0);  // c6
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0, 6'h01, {64'h0, DB}, 3'b000, 0);
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 0, 1, 10'h4, 32'h0, 4'h0, 6'h00, 96'h0, 3'b000, 1);  // c8
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0, 6'h04, {32'h0, DB, 32'h0}, 3'b000, 1);
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 0, 1, 10'h4, 32'h0, 4'h0, 6'h00, 96'h0, 3'b000, 2);  // c10
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0, 6'h10, {DB, 64'h0}, 3'b000, 2);
    v(0, 9'o002, 32'h10, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0, 6'h00, 96'h0, 3'b000, 0); // c12
    idle(0, 0, 0); idle(0, 0, 1); idle(0, 0, 1); idle(0, 0, 2); idle(0, 0, 2);        // c13-c17
    v(0, 9'o010, 32'h24, 32'h11112222, 4'h3, 0, 1, 10'h4, 32'h0, 4'h0, 6'h00, 96'h0, 3'b000, 0);
    v(0, 9'o010, 32'h28, 32'h33334444, 4'hF, 0, 0, 10'h0, 32'h0, 4'h0, 6'h01, {64'h0, DB}, 3'b000, 0);
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 1, 0, 10'h9, 32'h11112222, 4'h3, 6'h00, 96'h0, 3'b010, 1);
    v(0, 9'o010, 32'h2C, 32'h55556666, 4'hF, 0, 0, 10'h0, 32'h0, 4'h0, 6'h04, 96'h0, 3'b010, 1);
    idle(0, 3'b010, 2); idle(0, 3'b010, 2); idle(0, 3'b010, 0); idle(0, 3'b010, 0);   // c22-c25
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 1, 0, 10'hB, 32'h55556666, 4'hF, 6'h00, 96'h0, 3'b010, 1);
    v(0, 9'o000, 32'h0, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0, 6'h04, 96'h0, 3'b010, 1);  // c27
    idle(0, 3'b010, 2);                                                             // c28
    v(0, 9'o002, 32'h10, 32'h0, 4'h0, 0, 0, 10'h0, 32'h0, 4'h0, 6'h00, 96'h0, 3'b010, 2); // c29
    idle(1, 0, 0);                                                                  // c30: reset over the issue
    idle(0, 0, 0); idle(0, 0, 0); idle(0, 0, 1); idle(0, 0, 1);

    @(posedge clk);
    #1;
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].cmd, {C{tbl[k].addr}}, {C{tbl[k].data}}, {C{tbl[k].be}});
      check("tbl_strobes", {mem_wr, mem_rd}, {tbl[k].ewr, tbl[k].erd});
      if (tbl[k].ewr || tbl[k].erd || tbl[k].rst || post_rst)
        check("tbl_mem_bus", {mem_addr, mem_wd, mem_be}, {tbl[k].eaddr, tbl[k].ewd, tbl[k].ebe});
      check("tbl_resp", s_resp, tbl[k].eresp);
      check("tbl_s_data", s_data, tbl[k].edata);
      if (!tbl[k].rst) begin
        check("tbl_owner", owner, tbl[k].eown);
        check("tbl_ovf", ovf, tbl[k].eovf);
      end
      finish_cycle();
    end

    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < C; i++) begin
        r = $urandom_range(0, 99);
        if (r < 15)      rc[3*i +: 3] = CMD_WR;
        else if (r < 30) rc[3*i +: 3] = CMD_RD;
        else if (r < 32) rc[3*i +: 3] = 3'($urandom_range(3, 7));
        else             rc[3*i +: 3] = CMD_IDLE;
        a1 = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
        ra[32*i +: 32]   = a1;
        rdat[32*i +: 32] = $urandom();
        rb[4*i +: 4]     = 4'($urandom_range(0, 15));
      end
      drive(rr, rc, ra, rdat, rb);
      finish_cycle();
    end

    for (int n = 0; n < 2 * C + 2; n++) begin
      drive(1'b0, '0, '0, '0, '0);
      finish_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
